// File: rtl/nx_mesh_trigger_ctrl.sv
// Global trigger sequencer for the node mesh: waits for all-column idle, issues
// one-cycle triggers, masks the registered idle flags while they settle, counts cycles.
module nx_mesh_trigger_ctrl #(
  parameter int COLUMNS = 3,
  parameter int CYCLE_W = 32,
  parameter int SETTLE  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [CYCLE_W-1:0] i_cycle_limit,
  input  logic [COLUMNS-1:0] i_mesh_idle,
  output logic [COLUMNS-1:0] o_mesh_trigger,
  output logic               o_active,
  output logic [CYCLE_W-1:0] o_cycle,
  output logic               o_done
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_WAIT_IDLE,
    ST_TRIGGER,
    ST_SETTLE
  } state_t;

  state_t             state;
  logic [CYCLE_W-1:0] limit_q;
  logic               stop_pending;
  logic [SW-1:0]      settle_cnt;

  logic all_idle;
  logic limit_hit;

  assign all_idle  = &i_mesh_idle;
  // A zero limit means unbounded, so the counter may wrap without ending the run.
  assign limit_hit = (limit_q != '0) && (o_cycle == limit_q);

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_STOPPED;
      limit_q        <= '0;
      stop_pending   <= 1'b0;
      settle_cnt     <= '0;
      o_mesh_trigger <= '0;
      o_active       <= 1'b0;
      o_cycle        <= '0;
      o_done         <= 1'b0;
    end else begin
      o_mesh_trigger <= '0;
      o_done         <= 1'b0;

      if (state != ST_STOPPED && i_stop) begin
        stop_pending <= 1'b1;
      end

      case (state)
        ST_STOPPED: begin
          if (i_start) begin
            limit_q      <= i_cycle_limit;
            o_cycle      <= '0;
            stop_pending <= 1'b0;
            o_active     <= 1'b1;
            state        <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          // A stop arriving in this very cycle still beats a pending trigger.
          if (stop_pending || i_stop || limit_hit) begin
            o_active <= 1'b0;
            o_done   <= 1'b1;
            state    <= ST_STOPPED;
          end else if (all_idle) begin
            o_mesh_trigger <= '1;
            state          <= ST_TRIGGER;
          end
        end

        ST_TRIGGER: begin
          o_cycle    <= o_cycle + CYCLE_W'(1);
          settle_cnt <= SW'(SETTLE - 1);
          state      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_WAIT_IDLE;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end

        default: state <= ST_STOPPED;
      endcase
    end
  end

endmodule
